// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   clog2()                : ceiling log2, sizes pointers and the level counter
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 16;

  // Ceiling log2 for elaboration-time width calculation (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// an optional first-word-fall-through read mode.
//   fifo_clk / rst        : clock, synchronous active-high reset
//   fifo_wren/fifo_wrdata : push request and data
//   fifo_rden             : pop request
//   fifo_clr_err          : clears the sticky error flags
//   fifo_rddata           : read data (registered, or head word when FWFT=1)
//   fifo_full/empty/almost_full/almost_empty/level : registered status
//   fifo_overflow/underflow : sticky error flags
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  parameter bit          FWFT      = 1'b0
) (
  input  logic                    fifo_clk,
  input  logic                    rst,
  input  logic                    fifo_wren,
  input  logic [DATA_W-1:0]       fifo_wrdata,
  input  logic                    fifo_rden,
  input  logic                    fifo_clr_err,
  output logic [DATA_W-1:0]       fifo_rddata,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    fifo_almost_full,
  output logic                    fifo_almost_empty,
  output logic [clog2(DEPTH):0]   fifo_level,
  output logic                    fifo_overflow,
  output logic                    fifo_underflow
);

  localparam int unsigned AW    = clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [LVL_W-1:0]  level_next;
  logic              rd_acc, wr_acc;
  logic              full_next, empty_next, af_next, ae_next;
  logic              ovf_next, unf_next;
  logic [DATA_W-1:0] mem_rdata;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (fifo_clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (fifo_wrdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Accept decisions and next-state for pointers, level, status and flags.
  // A write while full is accepted only alongside a pop in the same cycle.
  always_comb begin
    rd_acc      = 1'b0;
    wr_acc      = 1'b0;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    level_next  = fifo_level;
    full_next   = fifo_full;
    empty_next  = fifo_empty;
    af_next     = fifo_almost_full;
    ae_next     = fifo_almost_empty;
    ovf_next    = fifo_overflow;
    unf_next    = fifo_underflow;

    rd_acc = fifo_rden & ~fifo_empty;
    wr_acc = fifo_wren & (~fifo_full | rd_acc);

    if (wr_acc) wr_ptr_next = wr_ptr + AW'(1);
    if (rd_acc) rd_ptr_next = rd_ptr + AW'(1);
    level_next = fifo_level + LVL_W'(wr_acc) - LVL_W'(rd_acc);

    // Status is derived from level_next so it always agrees with fifo_level.
    full_next  = (level_next == LVL_W'(DEPTH));
    empty_next = (level_next == '0);
    af_next    = (level_next >= LVL_W'(AF_THRESH));
    ae_next    = (level_next <= LVL_W'(AE_THRESH));

    // New error events win over a concurrent clear.
    ovf_next = (fifo_wren & ~wr_acc)     | (fifo_overflow  & ~fifo_clr_err);
    unf_next = (fifo_rden & fifo_empty)  | (fifo_underflow & ~fifo_clr_err);
  end

  // State registers.
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_level        <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
      fifo_overflow     <= 1'b0;
      fifo_underflow    <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_next;
      rd_ptr            <= rd_ptr_next;
      fifo_level        <= level_next;
      fifo_full         <= full_next;
      fifo_empty        <= empty_next;
      fifo_almost_full  <= af_next;
      fifo_almost_empty <= ae_next;
      fifo_overflow     <= ovf_next;
      fifo_underflow    <= unf_next;
    end
  end

  // Read data path: head word directly in FWFT mode, else a pop-loaded register.
  if (FWFT) begin : g_fwft
    assign fifo_rddata = mem_rdata;
  end else begin : g_rdreg
    always_ff @(posedge fifo_clk) begin
      if (rst) begin
        fifo_rddata <= '0;
      end else if (rd_acc) begin
        fifo_rddata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a registered-read and an FWFT instance share one
// stimulus stream and are compared every cycle against a queue model.
module tb_fifo_sync_param;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_TH  = DEPTH - 2;
  localparam int unsigned AE_TH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wren, rden, clr;
  logic [DATA_W-1:0] wrdata;

  logic [DATA_W-1:0] rd0, rd1;
  logic              full0, empty0, af0, ae0, ovf0, unf0;
  logic              full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]        lvl0, lvl1;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_TH),
                    .AE_THRESH(AE_TH), .FWFT(1'b0)) dut0 (
    .fifo_clk(clk), .rst(rst), .fifo_wren(wren), .fifo_wrdata(wrdata),
    .fifo_rden(rden), .fifo_clr_err(clr), .fifo_rddata(rd0),
    .fifo_full(full0), .fifo_empty(empty0), .fifo_almost_full(af0),
    .fifo_almost_empty(ae0), .fifo_level(lvl0), .fifo_overflow(ovf0),
    .fifo_underflow(unf0));

  fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_TH),
                    .AE_THRESH(AE_TH), .FWFT(1'b1)) dut1 (
    .fifo_clk(clk), .rst(rst), .fifo_wren(wren), .fifo_wrdata(wrdata),
    .fifo_rden(rden), .fifo_clr_err(clr), .fifo_rddata(rd1),
    .fifo_full(full1), .fifo_empty(empty1), .fifo_almost_full(af1),
    .fifo_almost_empty(ae1), .fifo_level(lvl1), .fifo_overflow(ovf1),
    .fifo_underflow(unf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags from the accept rules.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_rd;
  bit m_ovf, m_unf;
  bit m_em, m_fu, m_ra, m_wa;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd  = '0;
    end else begin
      m_em = (m_q.size() == 0);
      m_fu = (m_q.size() == DEPTH);
      m_ra = rden && !m_em;
      m_wa = wren && (!m_fu || m_ra);
      m_ovf = (wren && !m_wa) || (m_ovf && !clr);
      m_unf = (rden && m_em)  || (m_unf && !clr);
      if (m_ra) m_rd = m_q.pop_front();
      if (m_wa) m_q.push_back(wrdata);
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      int sz;
      sz = m_q.size();
      chk("level0", 32'(lvl0), 32'(sz));
      chk("level1", 32'(lvl1), 32'(sz));
      chk("full0",  32'(full0),  32'(sz == DEPTH));
      chk("full1",  32'(full1),  32'(sz == DEPTH));
      chk("empty0", 32'(empty0), 32'(sz == 0));
      chk("empty1", 32'(empty1), 32'(sz == 0));
      chk("af0",    32'(af0),    32'(sz >= AF_TH));
      chk("af1",    32'(af1),    32'(sz >= AF_TH));
      chk("ae0",    32'(ae0),    32'(sz <= AE_TH));
      chk("ae1",    32'(ae1),    32'(sz <= AE_TH));
      chk("ovf0",   32'(ovf0),   32'(m_ovf));
      chk("ovf1",   32'(ovf1),   32'(m_ovf));
      chk("unf0",   32'(unf0),   32'(m_unf));
      chk("unf1",   32'(unf1),   32'(m_unf));
      chk("rddata0", 32'(rd0),   32'(m_rd));
      if (sz > 0) chk("rddata1_head", 32'(rd1), 32'(m_q[0]));
    end
  end

  task automatic step(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
    wren = w; wrdata = d; rden = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    int pct;
    rst = 1'b1; wren = 0; rden = 0; clr = 0; wrdata = '0;
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    rst = 1'b0;
    started = 1'b1;
    chk("reset_level", 32'(lvl0), 0);
    chk("reset_empty", 32'(empty0), 1);
    chk("reset_ae", 32'(ae0), 1);
    chk("reset_rddata", 32'(rd0), 0);

    // Two writes, three reads.
    step(1, 16'd24, 0, 0); chk("t1_level_a", 32'(lvl0), 1);
    step(1, 16'd4, 0, 0);  chk("t1_level_b", 32'(lvl0), 2);
    step(0, '0, 1, 0);     chk("t1_rd_a", 32'(rd0), 24); chk("t1_level_c", 32'(lvl0), 1);
    step(0, '0, 1, 0);     chk("t1_rd_b", 32'(rd0), 4);  chk("t1_level_d", 32'(lvl0), 0);
    step(0, '0, 1, 0);     chk("t1_unf", 32'(unf0), 1);  chk("t1_rd_hold", 32'(rd0), 4);
    step(0, '0, 0, 1);     chk("t1_unf_clr", 32'(unf0), 0);

    // Fill, overflow, simultaneous push/pop at full, drain.
    for (int i = 0; i < 16; i++) begin
      step(1, DATA_W'(i), 0, 0);
      chk("t2_af", 32'(af0), 32'(i + 1 >= 14));
      chk("t2_full", 32'(full0), 32'(i == 15));
    end
    step(1, 16'd100, 0, 0);
    chk("t2_ovf", 32'(ovf0), 1); chk("t2_ovf_level", 32'(lvl0), 16);
    step(1, 16'd99, 1, 0);
    chk("t2_both_level", 32'(lvl0), 16); chk("t2_both_rd", 32'(rd0), 0);
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 0);
      chk("t2_drain", 32'(rd0), (i < 15) ? 32'(i + 1) : 32'd99);
    end
    chk("t2_empty", 32'(empty0), 1);
    chk("t2_not_both", 32'(full0 & empty0), 0);
    step(0, '0, 0, 1);

    // Wrap-around with interleaved write/read pairs.
    for (int i = 0; i < 40; i++) begin
      v = DATA_W'($urandom);
      step(1, v, 0, 0);
      chk("t3_level_max", 32'(lvl0 <= 2), 1);
      step(0, '0, 1, 0);
      chk("t3_data", 32'(rd0), 32'(v));
    end

    // FWFT: word visible without a pop.
    step(1, 16'hA5A5, 0, 0);
    chk("t4_fwft_rd", 32'(rd1), 32'h0000A5A5); chk("t4_fwft_empty", 32'(empty1), 0);
    step(0, '0, 1, 0);
    chk("t4_fwft_empty2", 32'(empty1), 1); chk("t4_reg_rd", 32'(rd0), 32'h0000A5A5);

    // Reset mid-stream at level 5.
    for (int i = 0; i < 5; i++) step(1, DATA_W'(i + 7), 0, 0);
    chk("t5_level5", 32'(lvl0), 5);
    rst = 1'b1;
    step(1, 16'd7, 1, 0);
    rst = 1'b0;
    chk("t5_level0", 32'(lvl0), 0); chk("t5_empty", 32'(empty0), 1);
    chk("t5_ovf", 32'(ovf0), 0);    chk("t5_unf", 32'(unf0), 0);
    chk("t5_af", 32'(af0), 0);      chk("t5_rd", 32'(rd0), 0);
    step(0, '0, 1, 1);
    chk("t5_unf_set_wins", 32'(unf0), 1);
    step(0, '0, 0, 1);

    // Random soak.
    for (int i = 0; i < 600; i++) begin
      pct = int'($urandom_range(0, 99));
      rst = (pct == 0);
      step($urandom_range(0, 99) < 55, DATA_W'($urandom),
           $urandom_range(0, 99) < 48, $urandom_range(0, 99) < 6);
    end
    rst = 1'b0;
    step(0, '0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
